// File: rtl/kong_controller.sv
// kong_controller: movement and animation controller for Kong.
//
// Collision edges and rope hits are OR-accumulated while the frame is
// drawn. On each start_of_frame pulse the FSM and the physics (position,
// vertical velocity, facing direction, sprite icon) advance by one frame.
// All outputs are registered and change one cycle after start_of_frame.
//
// Optional feature: define KONG_ROPE_EN to enable rope climbing
// (CLIMBING and JUMPING_FROM_ROPE states). Without it rope_hit is ignored.
//
// Ports:
//   clk            system clock
//   resetN         asynchronous active-low reset
//   start_of_frame one-cycle pulse per video frame
//   key_left/right/up/down/jump   level keys
//   plat_edge[3:0] platform collision edges, indexed by E_*
//   rope_hit       Kong/rope overlap pulse
//   kong_x, kong_y top-left corner of Kong
//   state          current FSM state
//   icon           sprite selector
//   direction      facing direction
//
// state                       | meaning
// KONG_IS_STANDING            | on a platform (or the screen floor)
// KONG_IS_JUMPING             | airborne, may land or grab a rope
// KONG_IS_JUMPING_IN_PLATFORM | rising through a platform, landing ignored
// KONG_IS_CLIMBING            | on a rope, vertical key motion only
// KONG_IS_JUMPING_FROM_ROPE   | airborne after leaving a rope, no re-grab

package kong_pkg;
  typedef logic [10:0] location;
  typedef enum logic [2:0] {
    KONG_IS_STANDING, KONG_IS_JUMPING, KONG_IS_JUMPING_IN_PLATFORM,
    KONG_IS_CLIMBING, KONG_IS_JUMPING_FROM_ROPE
  } kong_state;
  typedef enum logic [2:0] {
    KONG_STAND, KONG_WALK_LEFT, KONG_WALK_RIGHT, KONG_JUMP_LEFT,
    KONG_JUMP_RIGHT, KONG_CLIMB_LEFT, KONG_CLIMB_RIGHT
  } kong_icon;
  typedef enum logic {KONG_LOOK_LEFT, KONG_LOOK_RIGHT} kong_direction;
  localparam int E_LEFT = 0, E_TOP = 1, E_RIGHT = 2, E_BOTTOM = 3;
  localparam int SCREEN_WIDTH = 640, KONG_WIDTH = 64;
  localparam int SCREEN_HIGHT = 480, KONG_HIGHT = 48;
endpackage

module kong_controller
  import kong_pkg::*;
#(
  parameter location INIT_X      = 11'd32,
  parameter location INIT_Y      = 11'd384,
  parameter int      WALK_SPEED  = 2,
  parameter int      CLIMB_SPEED = 2,
  parameter int      JUMP_VY     = -8,
  parameter int      MAX_VY      = 8
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          start_of_frame,
  input  logic          key_left,
  input  logic          key_right,
  input  logic          key_up,
  input  logic          key_down,
  input  logic          key_jump,
  input  logic [3:0]    plat_edge,
  input  logic          rope_hit,
  output location       kong_x,
  output location       kong_y,
  output kong_state     state,
  output kong_icon      icon,
  output kong_direction direction
);

  localparam logic signed [12:0] X_MAX        = 13'(SCREEN_WIDTH - KONG_WIDTH);
  localparam logic signed [12:0] Y_MAX        = 13'(SCREEN_HIGHT - KONG_HIGHT);
  localparam location            Y_FLOOR      = 11'(SCREEN_HIGHT - KONG_HIGHT);
  localparam location            X_RIGHT      = 11'(SCREEN_WIDTH - KONG_WIDTH);
  localparam logic signed [12:0] WALK         = 13'(WALK_SPEED);
  localparam logic signed [10:0] CLIMB        = 11'(CLIMB_SPEED);
  localparam logic signed [10:0] VY_MAX       = 11'(MAX_VY);
  localparam logic signed [10:0] VY_JUMP      = 11'(JUMP_VY);
  localparam logic signed [10:0] VY_ROPE_JUMP = 11'(JUMP_VY / 2);

  logic [3:0]         edge_l, edges;
  logic               rope_now, bottom, climbing, move_l, move_r;
  logic signed [10:0] vy, vy_pre, vy_inc, vy_nxt, y_delta, climb_delta;
  logic signed [12:0] x_sum, y_sum;
  location            x_nxt, y_nxt;
  kong_state          state_nxt;
  kong_icon           icon_nxt;
  kong_direction      dir_nxt;
  logic [2:0]         climb_cnt, climb_cnt_nxt;
  logic               climb_phase, climb_phase_nxt;

  // A pulse coincident with start_of_frame belongs to the closing frame.
  assign edges = edge_l | plat_edge;

`ifdef KONG_ROPE_EN
  logic rope_l;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)             rope_l <= 1'b0;
    else if (start_of_frame) rope_l <= 1'b0;
    else                     rope_l <= rope_l | rope_hit;
  end
  assign rope_now = rope_l | rope_hit;
`else
  logic unused_rope;
  assign unused_rope = rope_hit;
  assign rope_now    = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      edge_l      <= 4'b0;
      state       <= KONG_IS_STANDING;
      kong_x      <= INIT_X;
      kong_y      <= INIT_Y;
      vy          <= '0;
      icon        <= KONG_STAND;
      direction   <= KONG_LOOK_RIGHT;
      climb_cnt   <= 3'd0;
      climb_phase <= 1'b0;
    end else begin
      edge_l <= start_of_frame ? 4'b0 : edges;
      if (start_of_frame) begin
        state       <= state_nxt;
        kong_x      <= x_nxt;
        kong_y      <= y_nxt;
        vy          <= vy_nxt;
        icon        <= icon_nxt;
        direction   <= dir_nxt;
        climb_cnt   <= climb_cnt_nxt;
        climb_phase <= climb_phase_nxt;
      end
    end
  end

  // Next state plus the velocity used for this frame's vertical step.
  always_comb begin
    bottom    = edges[E_BOTTOM] | (kong_y == Y_FLOOR);
    state_nxt = state;
    vy_pre    = vy;
    case (state)
      KONG_IS_STANDING: begin
        vy_pre = '0;
        if (key_jump) begin
          vy_pre    = VY_JUMP;
          state_nxt = KONG_IS_JUMPING;
        end else if (rope_now && (key_up || key_down))
          state_nxt = KONG_IS_CLIMBING;
        else if (!bottom)
          state_nxt = KONG_IS_JUMPING;
      end
      KONG_IS_JUMPING, KONG_IS_JUMPING_FROM_ROPE: begin
        if (vy[10] && edges[E_TOP])
          state_nxt = KONG_IS_JUMPING_IN_PLATFORM;
        else if (vy > 11'sd0 && bottom) begin
          vy_pre    = '0;
          state_nxt = KONG_IS_STANDING;
        end else if (state == KONG_IS_JUMPING) begin
          if (rope_now && key_up) begin
            vy_pre    = '0;
            state_nxt = KONG_IS_CLIMBING;
          end
        end else if (!rope_now)
          state_nxt = KONG_IS_JUMPING;
      end
      KONG_IS_JUMPING_IN_PLATFORM: begin
        if (edges == 4'b0) state_nxt = KONG_IS_JUMPING;
      end
      KONG_IS_CLIMBING: begin
        vy_pre = '0;
        if (key_jump) begin
          vy_pre    = VY_ROPE_JUMP;
          state_nxt = KONG_IS_JUMPING_FROM_ROPE;
        end else if (bottom && key_down)
          state_nxt = KONG_IS_STANDING;
        else if (!rope_now)
          state_nxt = KONG_IS_JUMPING;
      end
      default: state_nxt = KONG_IS_STANDING;
    endcase
  end

  // Physics, facing, climb animation and icon for the coming frame.
  always_comb begin
    climbing = (state == KONG_IS_CLIMBING);
    move_l   = key_left & ~key_right & ~edges[E_LEFT] & ~climbing;
    move_r   = key_right & ~key_left & ~edges[E_RIGHT] & ~climbing;

    x_sum = $signed({2'b00, kong_x});
    if (move_l) x_sum = x_sum - WALK;
    if (move_r) x_sum = x_sum + WALK;
    if (x_sum[12])          x_nxt = 11'd0;
    else if (x_sum > X_MAX) x_nxt = X_RIGHT;
    else                    x_nxt = x_sum[10:0];

    climb_delta = '0;
    if (key_up && !key_down)      climb_delta = -CLIMB;
    else if (key_down && !key_up) climb_delta = CLIMB;

    // Rope motion replaces gravity except on the frame Kong leaps off.
    if (climbing && state_nxt != KONG_IS_JUMPING_FROM_ROPE) y_delta = climb_delta;
    else                                                    y_delta = vy_pre;
    y_sum = $signed({2'b00, kong_y}) + $signed({{2{y_delta[10]}}, y_delta});
    if (y_sum[12])          y_nxt = 11'd0;
    else if (y_sum > Y_MAX) y_nxt = Y_FLOOR;
    else                    y_nxt = y_sum[10:0];

    vy_inc = vy_pre + 11'sd1;
    if (state_nxt == KONG_IS_STANDING || state_nxt == KONG_IS_CLIMBING) vy_nxt = '0;
    else if (vy_inc > VY_MAX)                                           vy_nxt = VY_MAX;
    else                                                                vy_nxt = vy_inc;

    dir_nxt = direction;
    if (key_left && !key_right)      dir_nxt = KONG_LOOK_LEFT;
    else if (key_right && !key_left) dir_nxt = KONG_LOOK_RIGHT;

    climb_cnt_nxt   = climb_cnt;
    climb_phase_nxt = climb_phase;
    if (state_nxt == KONG_IS_CLIMBING) begin
      if (!climbing) begin
        climb_cnt_nxt   = 3'd0;
        climb_phase_nxt = 1'b0;
      end else if (climb_delta != 11'sd0) begin
        climb_cnt_nxt = climb_cnt + 3'd1;
        if (climb_cnt == 3'd7) climb_phase_nxt = ~climb_phase;
      end
    end

    case (state_nxt)
      KONG_IS_STANDING: begin
        if (x_nxt < kong_x)      icon_nxt = KONG_WALK_LEFT;
        else if (x_nxt > kong_x) icon_nxt = KONG_WALK_RIGHT;
        else                     icon_nxt = KONG_STAND;
      end
      KONG_IS_CLIMBING: icon_nxt = climb_phase_nxt ? KONG_CLIMB_RIGHT : KONG_CLIMB_LEFT;
      default: icon_nxt = (dir_nxt == KONG_LOOK_LEFT) ? KONG_JUMP_LEFT : KONG_JUMP_RIGHT;
    endcase
  end

endmodule

// File: tb/tb_kong_controller.sv
module tb_kong_controller;
  import kong_pkg::*;

  logic          clk = 1'b0, resetN = 1'b0, start_of_frame = 1'b0;
  logic          key_left = 1'b0, key_right = 1'b0, key_up = 1'b0;
  logic          key_down = 1'b0, key_jump = 1'b0, rope_hit = 1'b0;
  logic [3:0]    plat_edge = 4'b0;
  location       kong_x, kong_y;
  kong_state     state;
  kong_icon      icon;
  kong_direction direction;

  kong_controller dut (
    .clk(clk), .resetN(resetN), .start_of_frame(start_of_frame),
    .key_left(key_left), .key_right(key_right), .key_up(key_up),
    .key_down(key_down), .key_jump(key_jump), .plat_edge(plat_edge),
    .rope_hit(rope_hit), .kong_x(kong_x), .kong_y(kong_y), .state(state),
    .icon(icon), .direction(direction)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] KL = 5'b10000, KR = 5'b01000, KU = 5'b00100, KJ = 5'b00001, K0 = 5'b00000;
  localparam logic [3:0] EL = 4'b0001, ET = 4'b0010, ER = 4'b0100, EB = 4'b1000, E0 = 4'b0000;

  typedef struct {
    int            id;
    location       x;
    location       y;
    kong_state     st;
    kong_icon      ic;
    kong_direction dir;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0, fid = 0;

  task automatic check(input string what, input int id, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL frame%0d %s actual=%0d required=%0d", id, what, act, req);
    end
  endtask

  task automatic check_outputs(input int id, input int ex, input int ey, input kong_state est,
                               input kong_icon eic, input kong_direction edir);
    check("x", id, int'(kong_x), ex);
    check("y", id, int'(kong_y), ey);
    check("state", id, int'(state), int'(est));
    check("icon", id, int'(icon), int'(eic));
    check("direction", id, int'(direction), int'(edir));
  endtask

  // One frame: mid-frame collision pulse, then the start_of_frame cycle
  // carrying es on plat_edge. The expected result is queued at that point.
  task automatic frame(input logic [4:0] keys, input logic [3:0] em, input logic [3:0] es,
                       input logic rp, input int gap, input int ex, input int ey,
                       input kong_state est, input kong_icon eic, input kong_direction edir);
    {key_left, key_right, key_up, key_down, key_jump} = keys;
    for (int i = 0; i < gap; i++) begin
      plat_edge = (i == 0) ? em : 4'b0;
      rope_hit  = (i == 0) ? rp : 1'b0;
      @(negedge clk);
    end
    plat_edge      = es;
    rope_hit       = 1'b0;
    start_of_frame = 1'b1;
    fid++;
    sb.push_back('{fid, 11'(ex), 11'(ey), est, eic, edir});
    @(negedge clk);
    start_of_frame = 1'b0;
    plat_edge      = 4'b0;
  endtask

  // Monitor: outputs are due one cycle after each start_of_frame.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (start_of_frame && resetN) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_update actual=update required=none");
        end else begin
          e = sb.pop_front();
          check_outputs(e.id, int'(e.x), int'(e.y), e.st, e.ic, e.dir);
        end
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  int fall_y[14] = '{353, 355, 358, 362, 367, 373, 380, 388, 396, 404, 412, 420, 428, 432};

  initial begin
    // Reset held while keys and edges are active.
    key_right = 1'b1;
    plat_edge = EB;
    repeat (3) @(negedge clk);
    check_outputs(0, 32, 384, KONG_IS_STANDING, KONG_STAND, KONG_LOOK_RIGHT);
    resetN = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs(0, 32, 384, KONG_IS_STANDING, KONG_STAND, KONG_LOOK_RIGHT);
    plat_edge = E0;

    // Walk right on a platform, then blocked, tie, and turn.
    for (int i = 1; i <= 10; i++)
      frame(KR, EB, E0, 1'b0, 3, 32 + 2 * i, 384, KONG_IS_STANDING, KONG_WALK_RIGHT, KONG_LOOK_RIGHT);
    frame(KR, EB | ER, E0, 1'b0, 3, 52, 384, KONG_IS_STANDING, KONG_STAND, KONG_LOOK_RIGHT);
    frame(KL | KR, EB, E0, 1'b0, 3, 52, 384, KONG_IS_STANDING, KONG_STAND, KONG_LOOK_RIGHT);
    frame(KL, EB, E0, 1'b0, 3, 50, 384, KONG_IS_STANDING, KONG_WALK_LEFT, KONG_LOOK_LEFT);
    // Left edge coincident with start_of_frame blocks only that frame.
    frame(KL, EB, EL, 1'b0, 3, 50, 384, KONG_IS_STANDING, KONG_STAND, KONG_LOOK_LEFT);
    frame(KL, EB, E0, 1'b0, 3, 48, 384, KONG_IS_STANDING, KONG_WALK_LEFT, KONG_LOOK_LEFT);

    // Jump, pass through a platform, land.
    frame(KJ, E0, E0, 1'b0, 3, 48, 376, KONG_IS_JUMPING, KONG_JUMP_LEFT, KONG_LOOK_LEFT);
    frame(K0, E0, E0, 1'b0, 3, 48, 369, KONG_IS_JUMPING, KONG_JUMP_LEFT, KONG_LOOK_LEFT);
    frame(K0, E0, E0, 1'b0, 3, 48, 363, KONG_IS_JUMPING, KONG_JUMP_LEFT, KONG_LOOK_LEFT);
    frame(K0, ET, E0, 1'b0, 3, 48, 358, KONG_IS_JUMPING_IN_PLATFORM, KONG_JUMP_LEFT, KONG_LOOK_LEFT);
    frame(K0, ET | EB, E0, 1'b0, 3, 48, 354, KONG_IS_JUMPING_IN_PLATFORM, KONG_JUMP_LEFT, KONG_LOOK_LEFT);
    frame(K0, EB, E0, 1'b0, 3, 48, 351, KONG_IS_JUMPING_IN_PLATFORM, KONG_JUMP_LEFT, KONG_LOOK_LEFT);
    frame(K0, EB, E0, 1'b0, 3, 48, 349, KONG_IS_JUMPING_IN_PLATFORM, KONG_JUMP_LEFT, KONG_LOOK_LEFT);
    frame(K0, EB, E0, 1'b0, 3, 48, 348, KONG_IS_JUMPING_IN_PLATFORM, KONG_JUMP_LEFT, KONG_LOOK_LEFT);
    frame(K0, EB, E0, 1'b0, 3, 48, 348, KONG_IS_JUMPING_IN_PLATFORM, KONG_JUMP_LEFT, KONG_LOOK_LEFT);
    frame(K0, EB, E0, 1'b0, 3, 48, 349, KONG_IS_JUMPING_IN_PLATFORM, KONG_JUMP_LEFT, KONG_LOOK_LEFT);
    frame(K0, E0, E0, 1'b0, 3, 48, 351, KONG_IS_JUMPING, KONG_JUMP_LEFT, KONG_LOOK_LEFT);
    frame(K0, EB, E0, 1'b0, 3, 48, 351, KONG_IS_STANDING, KONG_STAND, KONG_LOOK_LEFT);
    frame(KR, EB, E0, 1'b0, 3, 50, 351, KONG_IS_STANDING, KONG_WALK_RIGHT, KONG_LOOK_RIGHT);

    // Walk off the platform and land again.
    frame(K0, E0, E0, 1'b0, 3, 50, 351, KONG_IS_JUMPING, KONG_JUMP_RIGHT, KONG_LOOK_RIGHT);
    frame(K0, E0, E0, 1'b0, 3, 50, 352, KONG_IS_JUMPING, KONG_JUMP_RIGHT, KONG_LOOK_RIGHT);
    frame(K0, EB, E0, 1'b0, 3, 50, 352, KONG_IS_STANDING, KONG_STAND, KONG_LOOK_RIGHT);

    // Walk to the left screen edge and push against it.
    for (int i = 1; i <= 25; i++)
      frame(KL, EB, E0, 1'b0, 3, 50 - 2 * i, 352, KONG_IS_STANDING, KONG_WALK_LEFT, KONG_LOOK_LEFT);
    frame(KL, EB, E0, 1'b0, 3, 0, 352, KONG_IS_STANDING, KONG_STAND, KONG_LOOK_LEFT);

    // Free fall to the screen floor, which acts as a bottom collision.
    frame(K0, E0, E0, 1'b0, 3, 0, 352, KONG_IS_JUMPING, KONG_JUMP_LEFT, KONG_LOOK_LEFT);
    for (int i = 0; i < 14; i++)
      frame(K0, E0, E0, 1'b0, 3, 0, fall_y[i], KONG_IS_JUMPING, KONG_JUMP_LEFT, KONG_LOOK_LEFT);
    frame(K0, E0, E0, 1'b0, 3, 0, 432, KONG_IS_STANDING, KONG_STAND, KONG_LOOK_LEFT);
    frame(K0, E0, E0, 1'b0, 3, 0, 432, KONG_IS_STANDING, KONG_STAND, KONG_LOOK_LEFT);

    // Reset mid-frame with a right edge already latched.
    key_right = 1'b1;
    plat_edge = ER;
    @(negedge clk);
    plat_edge = E0;
    #2 resetN = 1'b0;
    #1 check_outputs(100, 32, 384, KONG_IS_STANDING, KONG_STAND, KONG_LOOK_RIGHT);
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    // Back-to-back start_of_frame pulses right after reset release.
    frame(KR, E0, EB, 1'b0, 0, 34, 384, KONG_IS_STANDING, KONG_WALK_RIGHT, KONG_LOOK_RIGHT);
    frame(KR, E0, EB, 1'b0, 0, 36, 384, KONG_IS_STANDING, KONG_WALK_RIGHT, KONG_LOOK_RIGHT);

`ifdef KONG_ROPE_EN
    // Grab the rope, climb 8 frames, leap off, re-grab refused, re-grab.
    frame(KU, EB, E0, 1'b1, 3, 36, 384, KONG_IS_CLIMBING, KONG_CLIMB_LEFT, KONG_LOOK_RIGHT);
    for (int i = 1; i <= 7; i++)
      frame(KU, E0, E0, 1'b1, 3, 36, 384 - 2 * i, KONG_IS_CLIMBING, KONG_CLIMB_LEFT, KONG_LOOK_RIGHT);
    frame(KU, E0, E0, 1'b1, 3, 36, 368, KONG_IS_CLIMBING, KONG_CLIMB_RIGHT, KONG_LOOK_RIGHT);
    frame(KJ, E0, E0, 1'b1, 3, 36, 364, KONG_IS_JUMPING_FROM_ROPE, KONG_JUMP_RIGHT, KONG_LOOK_RIGHT);
    frame(KU, E0, E0, 1'b1, 3, 36, 361, KONG_IS_JUMPING_FROM_ROPE, KONG_JUMP_RIGHT, KONG_LOOK_RIGHT);
    frame(K0, E0, E0, 1'b0, 3, 36, 359, KONG_IS_JUMPING, KONG_JUMP_RIGHT, KONG_LOOK_RIGHT);
    frame(KU, E0, E0, 1'b1, 3, 36, 359, KONG_IS_CLIMBING, KONG_CLIMB_LEFT, KONG_LOOK_RIGHT);
`else
    // Without rope support a rope hit with key_up leaves Kong standing.
    frame(KU, EB, E0, 1'b1, 3, 36, 384, KONG_IS_STANDING, KONG_STAND, KONG_LOOK_RIGHT);
    frame(KU, EB, E0, 1'b1, 3, 36, 384, KONG_IS_STANDING, KONG_STAND, KONG_LOOK_RIGHT);
`endif

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
